// File: rtl/regfile_pkg.sv
// Shared constants for the datapath register file: default widths used by
// decode/writeback and the clear-FSM state encoding.
package regfile_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } rf_state_e;

endpackage : regfile_pkg

// File: rtl/rf_read_port.sv
// One registered read port: selects zero / bypassed write data / array data,
// or holds its last value when not enabled.
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              block_i,
  input  logic              byp_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  // NOTE: the hold value is assigned first so every path drives rd_data_d and no latch is inferred.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en_i) begin
      if (block_i) begin
        rd_data_d = '0;
      end else if ((ZERO_REG != 0) && (rd_addr_i == '0)) begin
        rd_data_d = '0;
      end else if ((BYPASS != 0) && byp_en_i && (wr_addr_i == rd_addr_i)) begin
        rd_data_d = wr_data_i;
      end else begin
        rd_data_d = mem_data_i;
      end
    end
  end

  // NOTE: flops use non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule : rf_read_port

// File: rtl/reg_file_mp.sv
// Multi-read, single-write register file with a hardware clear FSM that
// zeroes every entry after reset or on clr_req.
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clr_req,
  output logic                     busy
);

  localparam int DEPTH = 1 << ADDR_W;

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              busy_q, busy_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              wr_fire;

  assign wr_fire = (state_q == ST_IDLE) && wr_en;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    busy_d    = busy_q;
    unique case (state_q)
      ST_CLEAR: begin
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == {ADDR_W{1'b1}}) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      ST_IDLE: begin
        if (clr_req) begin
          state_d   = ST_CLEAR;
          clr_ptr_d = '0;
          busy_d    = 1'b1;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      busy_q    <= busy_d;
    end
  end

  // Single array write port shared by the clear sweep and user writes;
  // a write coinciding with reset is lost.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (!rst_n) begin
      mem_we = 1'b0;
    end else if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_ptr_q;
      mem_wdata = '0;
    end else if (wr_en && !((ZERO_REG != 0) && (wr_addr == '0))) begin
      mem_we = 1'b1;
    end
  end

  // NOTE: the array is deliberately not reset; the clear FSM zeroes it, keeping it mappable to RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    rf_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_port (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_en_i   (rd_en[i]),
      .rd_addr_i (rd_addr[i*ADDR_W +: ADDR_W]),
      .block_i   (busy_q),
      .byp_en_i  (wr_fire),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .mem_data_i(mem[rd_addr[i*ADDR_W +: ADDR_W]]),
      .rd_data_o (rd_data[i*DATA_W +: DATA_W])
    );
  end

  assign busy = busy_q;

endmodule : reg_file_mp

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: two instances (bypass+zero-reg, and neither)
// share stimulus; expectations are queued at drive time and checked after the edge.
module tb_reg_file_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;
  localparam int BUSY  = -1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NR-1:0]  rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data_a, rd_data_b;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;
  logic           clr_req;
  logic           busy_a, busy_b;

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req), .busy(busy_a)
  );

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0), .BYPASS(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req), .busy(busy_b)
  );

  typedef struct {
    string         tag;
    bit            dut_b;
    int            sig;
    logic [DW-1:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [DW-1:0] observe(input bit dut_b, input int sig);
    logic [NR*DW-1:0] rd;
    rd = dut_b ? rd_data_b : rd_data_a;
    if (sig < 0) return DW'(dut_b ? busy_b : busy_a);
    return rd[sig*DW +: DW];
  endfunction

  task automatic push(input string tag, input int sig, input logic [DW-1:0] exp_a,
                      input logic [DW-1:0] exp_b);
    exp_t e;
    e.tag = tag; e.sig = sig;
    e.dut_b = 1'b0; e.exp = exp_a; sb_q.push_back(e);
    e.dut_b = 1'b1; e.exp = exp_b; sb_q.push_back(e);
  endtask

  task automatic drive(input logic rst, input logic [NR-1:0] en, input logic [AW-1:0] a0,
                       input logic [AW-1:0] a1, input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic clr);
    rst_n   = rst;
    rd_en   = en;
    rd_addr = {a1, a0};
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    clr_req = clr;
  endtask

  task automatic step();
    exp_t          e;
    logic [DW-1:0] obs;
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = observe(e.dut_b, e.sig);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s (%s sig %0d): observed %h expected %h",
               e.tag, e.dut_b ? "nobyp" : "byp", e.sig, obs, e.exp);
      end
    end
  endtask

  task automatic clear_window(input string tag, input logic [AW-1:0] addr);
    for (int c = 1; c <= DEPTH; c++) begin
      drive(1'b1, 2'b11, addr, addr, 1'b1, addr, $urandom, (c % 7 == 3));
      push({tag, "_busy"}, BUSY, DW'(c < DEPTH), DW'(c < DEPTH));
      push({tag, "_rd0"}, 0, '0, '0);
      push({tag, "_rd1"}, 1, '0, '0);
      step();
    end
  endtask

  initial begin
    // Reset edge: busy set, read registers cleared.
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b0);
    push("rst_busy", BUSY, 32'd1, 32'd1);
    push("rst_rd0", 0, '0, '0);
    push("rst_rd1", 1, '0, '0);
    step();

    // Clear sweep after reset with garbage writes and ignored clr_req.
    for (int c = 1; c <= DEPTH; c++) begin
      drive(1'b1, 2'b11, AW'(c), AW'(c + 3), 1'b1, AW'(c * 7), $urandom, (c % 7 == 3));
      push("init_busy", BUSY, DW'(c < DEPTH), DW'(c < DEPTH));
      push("init_rd0", 0, '0, '0);
      push("init_rd1", 1, '0, '0);
      step();
    end

    for (int a = 0; a < DEPTH; a += 2) begin
      drive(1'b1, 2'b11, AW'(a), AW'(a + 1), 1'b0, '0, '0, 1'b0);
      push("zero_rd0", 0, '0, '0);
      push("zero_rd1", 1, '0, '0);
      step();
    end

    // Write then read next cycle.
    drive(1'b1, 2'b00, '0, '0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    push("wr5_hold0", 0, '0, '0);
    step();
    drive(1'b1, 2'b01, 5'd5, '0, 1'b0, '0, '0, 1'b0);
    push("rd5_p0", 0, 32'hDEADBEEF, 32'hDEADBEEF);
    push("rd5_p1", 1, '0, '0);
    step();

    // Same-cycle write and read of r7 on both ports.
    drive(1'b1, 2'b00, '0, '0, 1'b1, 5'd7, 32'h0BADF00D, 1'b0);
    step();
    drive(1'b1, 2'b11, 5'd7, 5'd7, 1'b1, 5'd7, 32'h12345678, 1'b0);
    push("byp7_p0", 0, 32'h12345678, 32'h0BADF00D);
    push("byp7_p1", 1, 32'h12345678, 32'h0BADF00D);
    step();
    drive(1'b1, 2'b11, 5'd7, 5'd7, 1'b0, '0, '0, 1'b0);
    push("rd7_p0", 0, 32'h12345678, 32'h12345678);
    push("rd7_p1", 1, 32'h12345678, 32'h12345678);
    step();

    // Zero register: writes to r0 are discarded when ZERO_REG is set.
    drive(1'b1, 2'b00, '0, '0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
    step();
    drive(1'b1, 2'b11, 5'd0, 5'd5, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
    push("r0_byp_p0", 0, '0, 32'hFFFFFFFF);
    push("r0_byp_p1", 1, 32'hDEADBEEF, 32'hDEADBEEF);
    step();
    drive(1'b1, 2'b11, 5'd0, 5'd0, 1'b0, '0, '0, 1'b0);
    push("r0_p0", 0, '0, 32'hFFFFFFFF);
    push("r0_p1", 1, '0, 32'hFFFFFFFF);
    step();

    // Hold when rd_en is low.
    drive(1'b1, 2'b00, '0, '0, 1'b1, 5'd3, 32'hA5A5A5A5, 1'b0);
    step();
    drive(1'b1, 2'b10, '0, 5'd3, 1'b0, '0, '0, 1'b0);
    push("rd3_p1", 1, 32'hA5A5A5A5, 32'hA5A5A5A5);
    push("rd3_hold0", 0, '0, 32'hFFFFFFFF);
    step();
    drive(1'b1, 2'b00, 5'd3, 5'd3, 1'b1, 5'd3, 32'h1, 1'b0);
    push("hold_wr3", 1, 32'hA5A5A5A5, 32'hA5A5A5A5);
    step();
    drive(1'b1, 2'b00, 5'd3, 5'd3, 1'b0, '0, '0, 1'b0);
    push("hold_idle", 1, 32'hA5A5A5A5, 32'hA5A5A5A5);
    step();
    drive(1'b1, 2'b01, 5'd3, '0, 1'b0, '0, '0, 1'b0);
    push("rd3_new_p0", 0, 32'h1, 32'h1);
    push("rd3_new_p1", 1, 32'hA5A5A5A5, 32'hA5A5A5A5);
    step();

    // Requested clear; the write in the request cycle still lands.
    drive(1'b1, 2'b00, '0, '0, 1'b1, 5'd9, 32'h55, 1'b0);
    step();
    drive(1'b1, 2'b11, 5'd9, 5'd10, 1'b1, 5'd10, 32'h77, 1'b1);
    push("clr_req_busy", BUSY, 32'd1, 32'd1);
    push("clr_req_rd9", 0, 32'h55, 32'h55);
    push("clr_req_rd10", 1, 32'h77, '0);
    step();
    clear_window("clr", 5'd9);
    drive(1'b1, 2'b11, 5'd9, 5'd10, 1'b0, '0, '0, 1'b0);
    push("post_clr_rd9", 0, '0, '0);
    push("post_clr_rd10", 1, '0, '0);
    push("post_clr_busy", BUSY, '0, '0);
    step();

    // Reset at clear cycle 10 restarts the full sweep.
    drive(1'b1, 2'b00, '0, '0, 1'b1, 5'd12, 32'h12, 1'b0);
    step();
    drive(1'b1, 2'b00, '0, '0, 1'b0, '0, '0, 1'b1);
    push("clr2_busy", BUSY, 32'd1, 32'd1);
    step();
    for (int c = 1; c < 10; c++) begin
      drive(1'b1, 2'b00, '0, '0, 1'b0, '0, '0, 1'b0);
      push("clr2_mid_busy", BUSY, 32'd1, 32'd1);
      step();
    end
    drive(1'b0, 2'b00, '0, '0, 1'b1, 5'd12, 32'h99, 1'b0);
    push("midrst_busy", BUSY, 32'd1, 32'd1);
    push("midrst_rd0", 0, '0, '0);
    step();
    clear_window("restart", 5'd12);
    drive(1'b1, 2'b11, 5'd12, 5'd5, 1'b0, '0, '0, 1'b0);
    push("final_rd12", 0, '0, '0);
    push("final_rd5", 1, '0, '0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_reg_file_mp
